// File: rtl/axis2mat_frame_scheduler.sv
// Per-frame controller for the Y and UV AXI-stream-to-Mat converters: validates a
// frame command, pushes per-plane geometry into the parameter FIFOs and runs both handshakes.
module axis2mat_frame_scheduler #(
  parameter int DIM_W    = 11,
  parameter int AXI_W    = 64,
  parameter int Y_PIX_W  = 8,
  parameter int UV_PIX_W = 16,
  parameter int CNT_W    = 16
) (
  input  logic             ap_clk,
  input  logic             ap_rst,
  input  logic             cfg_valid,
  output logic             cfg_ready,
  input  logic [DIM_W-1:0] cfg_rows,
  input  logic [DIM_W-1:0] cfg_cols,
  output logic [DIM_W-1:0] y_rows_din,
  output logic             y_rows_write,
  input  logic             y_rows_full_n,
  output logic [DIM_W-1:0] uv_rows_din,
  output logic             uv_rows_write,
  input  logic             uv_rows_full_n,
  output logic [DIM_W-1:0] y_cols_din,
  output logic             y_cols_write,
  input  logic             y_cols_full_n,
  output logic [DIM_W-1:0] uv_cols_din,
  output logic             uv_cols_write,
  input  logic             uv_cols_full_n,
  output logic [4:0]       y_last_blk_width,
  output logic [4:0]       uv_last_blk_width,
  output logic             y_ap_start,
  input  logic             y_ap_ready,
  input  logic             y_ap_done,
  output logic             y_ap_continue,
  output logic             uv_ap_start,
  input  logic             uv_ap_ready,
  input  logic             uv_ap_done,
  output logic             uv_ap_continue,
  output logic             busy,
  output logic             frame_done,
  output logic             cfg_err,
  output logic [CNT_W-1:0] frame_count
);

  localparam int Y_PPW  = AXI_W / Y_PIX_W;
  localparam int UV_PPW = AXI_W / UV_PIX_W;

  typedef enum logic [2:0] {S_IDLE, S_CHECK, S_PUSH, S_START, S_WAIT, S_DONE} state_t;

  state_t           state_q;
  logic [DIM_W-1:0] rows_q, cols_q;
  logic [DIM_W-1:0] y_rows_q, y_cols_q, uv_rows_q, uv_cols_q;
  logic [4:0]       y_lbw_q, uv_lbw_q;
  logic [3:0]       wr_q;    // {uv_cols, uv_rows, y_cols, y_rows} written
  logic [1:0]       acc_q;   // {uv, y} start accepted
  logic [1:0]       done_q;  // {uv, y} done captured
  logic             cfg_err_q;
  logic [CNT_W-1:0] cnt_q;

  logic [3:0]       wr, full_n;
  logic [1:0]       start, ready, done_in, cont;
  logic             illegal;
  logic [DIM_W-1:0] uv_cols_c, y_mod, uv_mod;

  assign full_n  = {uv_cols_full_n, uv_rows_full_n, y_cols_full_n, y_rows_full_n};
  assign ready   = {uv_ap_ready, y_ap_ready};
  assign done_in = {uv_ap_done, y_ap_done};

  assign wr    = (state_q == S_PUSH)  ? ~wr_q  : 4'b0;
  assign start = (state_q == S_START) ? ~acc_q : 2'b0;
  // Done is acknowledged combinationally so the converter sees ap_continue in its done cycle.
  assign cont  = (state_q == S_START || state_q == S_WAIT) ? (done_in & ~done_q) : 2'b0;

  assign illegal   = (rows_q < DIM_W'(2)) || (cols_q < DIM_W'(2)) || rows_q[0] || cols_q[0];
  assign uv_cols_c = cols_q >> 1;
  assign y_mod     = cols_q % DIM_W'(Y_PPW);
  assign uv_mod    = uv_cols_c % DIM_W'(UV_PPW);

  assign {uv_cols_write, uv_rows_write, y_cols_write, y_rows_write} = wr;
  assign {uv_ap_start, y_ap_start}       = start;
  assign {uv_ap_continue, y_ap_continue} = cont;

  assign cfg_ready         = (state_q == S_IDLE);
  assign busy              = (state_q != S_IDLE);
  assign frame_done        = (state_q == S_DONE);
  assign cfg_err           = cfg_err_q;
  assign frame_count       = cnt_q;
  assign y_rows_din        = y_rows_q;
  assign y_cols_din        = y_cols_q;
  assign uv_rows_din       = uv_rows_q;
  assign uv_cols_din       = uv_cols_q;
  assign y_last_blk_width  = y_lbw_q;
  assign uv_last_blk_width = uv_lbw_q;

  always_ff @(posedge ap_clk or posedge ap_rst) begin
    if (ap_rst) begin
      state_q   <= S_IDLE;
      rows_q    <= '0;
      cols_q    <= '0;
      y_rows_q  <= '0;
      y_cols_q  <= '0;
      uv_rows_q <= '0;
      uv_cols_q <= '0;
      y_lbw_q   <= '0;
      uv_lbw_q  <= '0;
      wr_q      <= '0;
      acc_q     <= '0;
      done_q    <= '0;
      cfg_err_q <= 1'b0;
      cnt_q     <= '0;
    end else begin
      done_q <= done_q | cont;
      case (state_q)
        S_IDLE: if (cfg_valid) begin
          rows_q    <= cfg_rows;
          cols_q    <= cfg_cols;
          cfg_err_q <= 1'b0;
          state_q   <= S_CHECK;
        end
        S_CHECK: if (illegal) begin
          cfg_err_q <= 1'b1;
          state_q   <= S_IDLE;
        end else begin
          y_rows_q  <= rows_q;
          y_cols_q  <= cols_q;
          uv_rows_q <= rows_q >> 1;
          uv_cols_q <= uv_cols_c;
          y_lbw_q   <= (y_mod == '0)  ? 5'(Y_PPW)  : 5'(y_mod);
          uv_lbw_q  <= (uv_mod == '0) ? 5'(UV_PPW) : 5'(uv_mod);
          state_q   <= S_PUSH;
        end
        S_PUSH: begin
          wr_q <= wr_q | (wr & full_n);
          if (&wr_q) state_q <= S_START;
        end
        S_START: begin
          acc_q <= acc_q | (start & ready);
          if (&acc_q) state_q <= S_WAIT;
        end
        S_WAIT: if (&done_q) state_q <= S_DONE;
        S_DONE: begin
          cnt_q   <= cnt_q + 1'b1;
          wr_q    <= '0;
          acc_q   <= '0;
          done_q  <= '0;
          state_q <= S_IDLE;
        end
        default: state_q <= S_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_axis2mat_frame_scheduler.sv
// Directed bench for axis2mat_frame_scheduler: geometry derivation, FIFO backpressure,
// skewed done handshakes, illegal commands and asynchronous reset.
module tb_axis2mat_frame_scheduler;

  logic        ap_clk, ap_rst, cfg_valid, cfg_ready;
  logic [10:0] cfg_rows, cfg_cols;
  logic [10:0] y_rows_din, uv_rows_din, y_cols_din, uv_cols_din;
  logic        y_rows_write, uv_rows_write, y_cols_write, uv_cols_write;
  logic        y_rows_full_n, uv_rows_full_n, y_cols_full_n, uv_cols_full_n;
  logic [4:0]  y_last_blk_width, uv_last_blk_width;
  logic        y_ap_start, y_ap_ready, y_ap_done, y_ap_continue;
  logic        uv_ap_start, uv_ap_ready, uv_ap_done, uv_ap_continue;
  logic        busy, frame_done, cfg_err;
  logic [15:0] frame_count;

  int checks = 0, failures = 0;
  int n_yr = 0, n_yc = 0, n_ur = 0, n_uc = 0;
  int n_ys = 0, n_us = 0, n_ycont = 0, n_ucont = 0;

  axis2mat_frame_scheduler dut (
    .ap_clk(ap_clk), .ap_rst(ap_rst),
    .cfg_valid(cfg_valid), .cfg_ready(cfg_ready), .cfg_rows(cfg_rows), .cfg_cols(cfg_cols),
    .y_rows_din(y_rows_din), .y_rows_write(y_rows_write), .y_rows_full_n(y_rows_full_n),
    .uv_rows_din(uv_rows_din), .uv_rows_write(uv_rows_write), .uv_rows_full_n(uv_rows_full_n),
    .y_cols_din(y_cols_din), .y_cols_write(y_cols_write), .y_cols_full_n(y_cols_full_n),
    .uv_cols_din(uv_cols_din), .uv_cols_write(uv_cols_write), .uv_cols_full_n(uv_cols_full_n),
    .y_last_blk_width(y_last_blk_width), .uv_last_blk_width(uv_last_blk_width),
    .y_ap_start(y_ap_start), .y_ap_ready(y_ap_ready), .y_ap_done(y_ap_done),
    .y_ap_continue(y_ap_continue),
    .uv_ap_start(uv_ap_start), .uv_ap_ready(uv_ap_ready), .uv_ap_done(uv_ap_done),
    .uv_ap_continue(uv_ap_continue),
    .busy(busy), .frame_done(frame_done), .cfg_err(cfg_err), .frame_count(frame_count)
  );

  initial ap_clk = 1'b0;
  always #5 ap_clk = ~ap_clk;

  // Transaction counters seen at the active edge.
  always @(posedge ap_clk) begin
    if (y_rows_write && y_rows_full_n)   n_yr++;
    if (y_cols_write && y_cols_full_n)   n_yc++;
    if (uv_rows_write && uv_rows_full_n) n_ur++;
    if (uv_cols_write && uv_cols_full_n) n_uc++;
    if (y_ap_start && y_ap_ready)        n_ys++;
    if (uv_ap_start && uv_ap_ready)      n_us++;
    if (y_ap_continue)                   n_ycont++;
    if (uv_ap_continue)                  n_ucont++;
  end

  task automatic chk(input string tag, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %0d expected %0d", tag, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge ap_clk);
    #1;
  endtask

  function automatic logic [3:0] wrs();
    return {uv_cols_write, uv_rows_write, y_cols_write, y_rows_write};
  endfunction

  task automatic begin_frame(input int r, c, yr, yc, ur, uc, ylbw, ulbw, hold);
    int b_yr, b_yc, b_ur, b_uc, b_ys, b_us;
    b_yr = n_yr; b_yc = n_yc; b_ur = n_ur; b_uc = n_uc; b_ys = n_ys; b_us = n_us;
    uv_cols_full_n = (hold == 0);
    cfg_rows = 11'(r); cfg_cols = 11'(c); cfg_valid = 1'b1;
    #1 chk("cfg_ready_idle", cfg_ready, 1);
    tick();
    cfg_valid = 1'b0;
    chk("cfg_err_clear", cfg_err, 0);
    chk("busy_check", busy, 1);
    chk("cfg_ready_busy", cfg_ready, 0);
    tick();
    chk("wr_first_push", wrs(), 4'hF);
    chk("y_rows_din", y_rows_din, yr);
    chk("y_cols_din", y_cols_din, yc);
    chk("uv_rows_din", uv_rows_din, ur);
    chk("uv_cols_din", uv_cols_din, uc);
    chk("y_lbw", y_last_blk_width, ylbw);
    chk("uv_lbw", uv_last_blk_width, ulbw);
    for (int i = 0; i < hold; i++) begin
      chk("uvc_wr_held", uv_cols_write, 1);
      tick();
    end
    if (hold > 0) begin
      uv_cols_full_n = 1'b1;
      chk("others_done", {uv_rows_write, y_cols_write, y_rows_write}, 0);
      chk("uvc_wr_last", uv_cols_write, 1);
    end
    tick();
    chk("wr_idle", wrs(), 0);
    for (int i = 0; i < 20 && !(n_ys > b_ys && n_us > b_us); i++) tick();
    chk("y_start_cnt", n_ys - b_ys, 1);
    chk("uv_start_cnt", n_us - b_us, 1);
    chk("wr_cnt", {8'(n_uc - b_uc), 8'(n_ur - b_ur), 8'(n_yc - b_yc), 8'(n_yr - b_yr)},
        32'h01010101);
  endtask

  // uv done first; y done y_extra cycles later (0 = same cycle).
  task automatic finish_frame(input int y_extra, input int exp_cnt);
    int b_yc, b_uc;
    b_yc = n_ycont; b_uc = n_ucont;
    uv_ap_done = 1'b1;
    y_ap_done  = (y_extra == 0);
    #1 chk("uv_cont", uv_ap_continue, 1);
    chk("y_cont_first", y_ap_continue, (y_extra == 0));
    tick();
    y_ap_done = 1'b0;
    if (y_extra > 0) begin
      for (int i = 1; i < y_extra; i++) begin
        chk("uv_cont_once", uv_ap_continue, 0);
        chk("no_early_done", frame_done, 0);
        tick();
      end
      uv_ap_done = 1'b0;
      y_ap_done  = 1'b1;
      #1 chk("y_cont_late", y_ap_continue, 1);
      tick();
      y_ap_done = 1'b0;
    end
    uv_ap_done = 1'b0;
    chk("frame_done_d1", frame_done, 0);
    tick();
    chk("frame_done_d2", frame_done, 1);
    tick();
    chk("frame_done_off", frame_done, 0);
    chk("frame_count", frame_count, exp_cnt);
    chk("cfg_ready_after", cfg_ready, 1);
    chk("cont_cnt", {16'(n_ucont - b_uc), 16'(n_ycont - b_yc)}, 32'h00010001);
  endtask

  task automatic bad_cmd(input int r, c);
    int b;
    b = n_yr + n_yc + n_ur + n_uc + n_ys + n_us;
    cfg_rows = 11'(r); cfg_cols = 11'(c); cfg_valid = 1'b1;
    tick();
    cfg_valid = 1'b0;
    tick();
    chk("cfg_err_set", cfg_err, 1);
    chk("err_idle", {busy, cfg_ready}, 2'b01);
    repeat (3) tick();
    chk("err_no_activity", n_yr + n_yc + n_ur + n_uc + n_ys + n_us - b, 0);
    chk("err_sticky", cfg_err, 1);
  endtask

  initial begin
    ap_rst = 1'b1; cfg_valid = 1'b0; cfg_rows = '0; cfg_cols = '0;
    y_rows_full_n = 1'b1; y_cols_full_n = 1'b1; uv_rows_full_n = 1'b1; uv_cols_full_n = 1'b1;
    y_ap_ready = 1'b1; uv_ap_ready = 1'b1; y_ap_done = 1'b0; uv_ap_done = 1'b0;
    #12;
    chk("rst_outputs", {busy, frame_done, cfg_err, y_ap_start, uv_ap_start, wrs()}, 0);
    chk("rst_ready", cfg_ready, 1);
    chk("rst_count", frame_count, 0);
    chk("rst_din", {y_rows_din, y_cols_din, y_last_blk_width}, 0);
    ap_rst = 1'b0;
    tick();

    begin_frame(1080, 1920, 1080, 1920, 540, 960, 8, 4, 0);
    finish_frame(0, 1);
    begin_frame(4, 1918, 4, 1918, 2, 959, 6, 3, 0);
    finish_frame(0, 2);
    begin_frame(720, 1280, 720, 1280, 360, 640, 8, 4, 5);
    finish_frame(0, 3);
    begin_frame(6, 20, 6, 20, 3, 10, 4, 2, 0);
    finish_frame(20, 4);

    bad_cmd(3, 8);
    bad_cmd(2, 1);
    begin_frame(2, 12, 2, 12, 1, 6, 4, 2, 0);
    finish_frame(0, 5);

    begin_frame(8, 16, 8, 16, 4, 8, 8, 4, 0);
    tick();
    #2 ap_rst = 1'b1;
    #1;
    chk("arst_busy", busy, 0);
    chk("arst_count", frame_count, 0);
    chk("arst_din", {y_rows_din, uv_cols_din, y_last_blk_width, uv_last_blk_width}, 0);
    chk("arst_strobes", {y_ap_start, uv_ap_start, y_ap_continue, uv_ap_continue, wrs()}, 0);
    tick();
    ap_rst = 1'b0;
    tick();
    chk("post_rst_ready", cfg_ready, 1);
    chk("post_rst_count", frame_count, 0);
    begin_frame(2, 2, 2, 2, 1, 1, 2, 1, 0);
    finish_frame(0, 1);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/axis2mat_frame_scheduler.md
Name: axis2mat_frame_scheduler

Overview:
Per-frame controller for the two AXI-stream-to-Mat converters in the preprocessing pipeline: one for luma (Y) and one for interleaved chroma (UV). It accepts one frame-geometry command and derives the per-plane rows, cols-bound and last-block-width values. It pushes rows/cols into each converter's depth-limited parameter FIFOs, then drives both converters' ap_start/ap_ready/ap_done/ap_continue handshakes concurrently. It reports frame completion once both planes finish.

Parameters:
DIM_W, 11, width of rows/cols quantities
AXI_W, 64, input stream word width in bits
Y_PIX_W, 8, luma pixel width in bits (Y pixels per word = AXI_W/Y_PIX_W = 8)
UV_PIX_W, 16, chroma pair width in bits (UV pixels per word = 4)
CNT_W, 16, frame counter width

Ports:
ap_clk  in  1  clock
ap_rst  in  1  reset, asynchronous, active-high
cfg_valid  in  1  frame command valid
cfg_ready  out  1  command accepted when valid&ready
cfg_rows  in  DIM_W  frame height in lines
cfg_cols  in  DIM_W  frame width in pixels
y_rows_din / uv_rows_din  out  DIM_W  rows parameter FIFO data
y_rows_write / uv_rows_write  out  1  rows FIFO write strobe
y_rows_full_n / uv_rows_full_n  in  1  rows FIFO not full
y_cols_din / uv_cols_din  out  DIM_W  cols-bound-per-npc FIFO data
y_cols_write / uv_cols_write  out  1  cols FIFO write strobe
y_cols_full_n / uv_cols_full_n  in  1  cols FIFO not full
y_last_blk_width / uv_last_blk_width  out  5  pixels valid in the last word of a line, held stable for the frame
y_ap_start / uv_ap_start  out  1  converter start
y_ap_ready / uv_ap_ready  in  1  converter accepted start
y_ap_done / uv_ap_done  in  1  converter finished
y_ap_continue / uv_ap_continue  out  1  converter done acknowledge
busy  out  1  high in any state other than IDLE
frame_done  out  1  one-cycle pulse per completed frame
cfg_err  out  1  sticky; set on illegal command; cleared by the next accepted command
frame_count  out  CNT_W  completed frames; wraps modulo 2^CNT_W

Behaviour:
- Reset (async assert, sync-released FSM): state=IDLE. All strobes, ap_start, ap_continue, frame_done, busy and cfg_err are 0; frame_count=0. Din outputs and last_blk_width are 0. Reset mid-frame abandons the frame without ap_continue; the environment resets the converters together with this block.
- IDLE: cfg_ready=1. On cfg_valid, latch rows/cols and go to CHECK. cfg_ready=0 in all other states.
- CHECK (1 cycle): illegal if rows<2, cols<2, rows odd or cols odd. If illegal, set cfg_err and return to IDLE; no FIFO writes and no start. If legal, register the derived values and go to PUSH:
  - y_rows=rows, y_cols=cols.
  - uv_rows=rows>>1, uv_cols=cols>>1.
  - y_lbw = (cols mod 8)==0 ? 8 : cols mod 8.
  - uv_lbw = (uv_cols mod 4)==0 ? 4 : uv_cols mod 4.
- PUSH: four independent write flags, one per FIFO. Each FIFO's write is asserted while its flag is clear. A write completes in a cycle where write=1 and full_n=1; its flag then sets and write deasserts. No FIFO is written more than once per frame. Writes to non-full FIFOs occur in the same cycle. Exit to START the cycle after all four flags are set.
- START: y_ap_start and uv_ap_start are asserted together. Each deasserts the cycle after its own ap_start&ap_ready. When both have been accepted, go to WAIT.
- Done capture (active in START and WAIT): ap_done=1 for a plane sets that plane's done flag and drives its ap_continue=1 in the same cycle, exactly once per frame. A done seen in the same cycle as ready is captured.
- WAIT: when both done flags are set, go to DONE. Completion order Y/UV is arbitrary.
- DONE (1 cycle): frame_done=1, frame_count+1, clear all flags, go to IDLE. The next command is accepted no earlier than the following cycle.
- Command-to-first-write latency: 2 cycles (accept, CHECK, write in PUSH).

Test Plan:
- rows=1080, cols=1920, all FIFOs non-full, children ready immediately -> one write each: y 1080/1920, uv 540/960. y_lbw=8, uv_lbw=4. Both starts accepted, frame_done pulses, frame_count=1.
- cols=1918, rows=4 -> y_lbw=6, uv_cols=959, uv_lbw=3, uv_rows=2.
- uv_cols_full_n held 0 for 5 cycles, others free -> the other three write in the first PUSH cycle. uv_cols_write is held for 5 cycles and completes on the 6th. No duplicate writes.
- y_ap_done 20 cycles after uv_ap_done -> uv_ap_continue pulses first, y_ap_continue pulses 20 cycles later. frame_done follows y's done by 2 cycles.
- cfg rows=3, cols=8 -> cfg_err=1, no writes, no starts, returns to IDLE. Next legal command clears cfg_err.
- ap_rst asserted during WAIT -> outputs go to reset values immediately (asynchronously). frame_count=0 and cfg_ready=1 after release.
